// File: rtl/key_cmd_pkg.sv
// Shared command codes, key-repeat state encodings and arbiter priority helper.
package key_cmd_pkg;

   localparam int unsigned NUM_KEYS = 4;
   localparam int unsigned CMD_W    = 2;

   typedef enum logic [CMD_W-1:0] {
      CMD_LEFT   = 2'b00,
      CMD_RIGHT  = 2'b01,
      CMD_ROTATE = 2'b10,
      CMD_DROP   = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_DELAY  = 2'b01,
      ST_REPEAT = 2'b10
   } key_state_e;

   // Drop beats rotate beats left beats right; bit index equals command code.
   function automatic cmd_e prio_pick(input logic [NUM_KEYS-1:0] pend);
      cmd_e sel;
      if (pend[3])      sel = CMD_DROP;
      else if (pend[2]) sel = CMD_ROTATE;
      else if (pend[0]) sel = CMD_LEFT;
      else              sel = CMD_RIGHT;
      return sel;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// One key's press/auto-repeat FSM with its cycle counter and sticky pend flag.
module key_repeat
   import key_cmd_pkg::*;
#(
   parameter int unsigned DELAY     = 20'd500000,
   parameter int unsigned RATE      = 20'd100000,
   parameter int unsigned CNTW      = 20,
   parameter bit          REPEAT_EN = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic grant,
   output logic pend
);

   localparam logic [CNTW-1:0] DELAY_LAST = CNTW'(DELAY - 32'd1);
   localparam logic [CNTW-1:0] RATE_LAST  = CNTW'(RATE - 32'd1);

   key_state_e      state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            pend_q, pend_d;
   logic            fire_c;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire_c  = 1'b0;
      if (!btn) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               fire_c  = 1'b1;
               cnt_d   = '0;
               state_d = ST_DELAY;
            end
            ST_DELAY: begin
               // Non-repeating keys park here with the counter frozen.
               if (cnt_q == DELAY_LAST) begin
                  if (REPEAT_EN) begin
                     fire_c  = 1'b1;
                     cnt_d   = '0;
                     state_d = ST_REPEAT;
                  end
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
            ST_REPEAT: begin
               if (cnt_q == RATE_LAST) begin
                  fire_c = 1'b1;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
      // A fire on the grant edge wins so the request is never lost.
      pend_d = fire_c | (pend_q & ~grant);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   assign pend = pend_q;

endmodule

// File: rtl/key_cmd_sched.sv
// Four key-repeat channels feeding a fixed-priority arbiter with a valid/ready output register.
module key_cmd_sched
   import key_cmd_pkg::*;
#(
   parameter int unsigned DELAY = 20'd500000,
   parameter int unsigned RATE  = 20'd100000,
   parameter int unsigned CNTW  = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] btn,
   input  logic                cmd_ready,
   output logic                cmd_valid,
   output logic [CMD_W-1:0]    cmd
);

   logic [NUM_KEYS-1:0] pend;
   logic [NUM_KEYS-1:0] grant_c;
   logic                load_c;
   logic                cmd_valid_q, cmd_valid_d;
   cmd_e                cmd_q, cmd_d;

   // Left/right (bits 0,1) auto-repeat; rotate/drop fire once per press.
   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_repeat #(
         .DELAY     (DELAY),
         .RATE      (RATE),
         .CNTW      (CNTW),
         .REPEAT_EN (i < 2)
      ) u_key (
         .clk   (clk),
         .rst   (rst),
         .btn   (btn[i]),
         .grant (grant_c[i]),
         .pend  (pend[i])
      );
   end

   always_comb begin
      grant_c     = '0;
      cmd_valid_d = cmd_valid_q;
      cmd_d       = cmd_q;
      load_c      = !cmd_valid_q || cmd_ready;
      if (load_c) begin
         cmd_valid_d = |pend;
         if (|pend) begin
            cmd_d          = prio_pick(pend);
            grant_c[cmd_d] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cmd_valid_q <= 1'b0;
         cmd_q       <= CMD_LEFT;
      end else begin
         cmd_valid_q <= cmd_valid_d;
         cmd_q       <= cmd_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd       = cmd_q;

endmodule

// File: tb/tb_key_cmd_sched.sv
// Randomized and directed checks of key_cmd_sched against a hold-duration based reference model.
module tb_key_cmd_sched;

   localparam int DLY = 8;
   localparam int RT  = 4;

   logic       clk;
   logic       rst;
   logic [3:0] btn;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [1:0] cmd;

   key_cmd_sched #(
      .DELAY (DLY),
      .RATE  (RT),
      .CNTW  (20)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn),
      .cmd_ready (cmd_ready),
      .cmd_valid (cmd_valid),
      .cmd       (cmd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t0     = 0;

   // Reference model: consecutive-hold length per key, pending flags, output register.
   int   held [4];
   bit   mpend[4];
   bit   mvalid;
   int   mcmd;
   int   order[4] = '{3, 2, 0, 1};

   int   log_t[$];
   int   log_c[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         held[k]  = 0;
         mpend[k] = 1'b0;
      end
      mvalid = 1'b0;
      mcmd   = 0;
   endtask

   function automatic bit fires(input int k, input int h);
      if (h == 1) return 1'b1;
      if (k < 2 && h > DLY && ((h - 1 - DLY) % RT) == 0) return 1'b1;
      return 1'b0;
   endfunction

   // Drive one cycle from a negedge, advance the model at the posedge, compare just after it.
   task automatic step(input logic [3:0] b, input logic r);
      bit newp[4];
      bit found;
      btn       = b;
      cmd_ready = r;
      @(posedge clk);
      newp  = mpend;
      found = 1'b0;
      if (!mvalid || r) begin
         for (int j = 0; j < 4; j++) begin
            if (!found && mpend[order[j]]) begin
               found              = 1'b1;
               mcmd               = order[j];
               newp[order[j]]     = 1'b0;
            end
         end
         mvalid = found;
      end
      for (int k = 0; k < 4; k++) begin
         held[k] = b[k] ? held[k] + 1 : 0;
         if (fires(k, held[k])) newp[k] = 1'b1;
      end
      mpend = newp;
      cyc++;
      #1;
      chk("cmd_valid", int'(cmd_valid), int'(mvalid));
      chk("cmd", int'(cmd), mcmd);
      if (cmd_valid) begin
         log_t.push_back(cyc - t0);
         log_c.push_back(int'(cmd));
      end
      @(negedge clk);
   endtask

   task automatic start_scenario();
      log_t.delete();
      log_c.delete();
      t0 = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'b0000, 1'b1);
   endtask

   int exp_hold[7] = '{2, 10, 14, 18, 22, 26, 30};
   int exp_all[4]  = '{3, 2, 0, 1};
   int vcount;
   logic [3:0] rb;

   initial begin
      rst       = 1'b0;
      btn       = 4'b0000;
      cmd_ready = 1'b1;
      model_reset();
      #1;
      chk("reset_valid", int'(cmd_valid), 0);
      chk("reset_cmd", int'(cmd), 0);
      @(negedge clk);
      rst = 1'b1;

      // Single tap
      start_scenario();
      step(4'b0001, 1'b1);
      idle(8);
      chk("tap_count", log_t.size(), 1);
      if (log_t.size() >= 1) begin
         chk("tap_time", log_t[0], 2);
         chk("tap_cmd", log_c[0], 0);
      end

      // Hold left 30 cycles
      start_scenario();
      for (int i = 0; i < 30; i++) step(4'b0001, 1'b1);
      idle(8);
      chk("hold_left_count", log_t.size(), 7);
      for (int i = 0; i < 7 && i < log_t.size(); i++) begin
         chk("hold_left_time", log_t[i], exp_hold[i]);
         chk("hold_left_cmd", log_c[i], 0);
      end

      // Hold drop 30 cycles
      start_scenario();
      for (int i = 0; i < 30; i++) step(4'b1000, 1'b1);
      idle(8);
      chk("hold_drop_count", log_t.size(), 1);
      if (log_t.size() >= 1) chk("hold_drop_cmd", log_c[0], 3);

      // All four keys on the same edge
      start_scenario();
      for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
      idle(8);
      chk("all_count", log_t.size(), 4);
      for (int i = 0; i < 4 && i < log_t.size(); i++) begin
         chk("all_time", log_t[i], i + 2);
         chk("all_cmd", log_c[i], exp_all[i]);
      end

      // Backpressure: output holds, repeats coalesce into one extra command
      start_scenario();
      for (int i = 0; i < 20; i++) begin
         step(4'b0001, 1'b0);
         if (i >= 1) begin
            chk("stall_valid", int'(cmd_valid), 1);
            chk("stall_cmd", int'(cmd), 0);
         end
      end
      start_scenario();
      idle(8);
      chk("coalesce_count", log_t.size(), 1);

      // Asynchronous reset while a repeat command is presented
      start_scenario();
      for (int i = 0; i < 14; i++) step(4'b0001, 1'b1);
      chk("pre_reset_valid", int'(cmd_valid), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset_valid", int'(cmd_valid), 0);
      chk("async_reset_cmd", int'(cmd), 0);
      model_reset();
      #1;
      rst = 1'b1;
      start_scenario();
      for (int i = 0; i < 3; i++) step(4'b0001, 1'b1);
      idle(8);
      chk("post_reset_count", log_t.size(), 1);
      if (log_t.size() >= 1) begin
         chk("post_reset_time", log_t[0], 2);
         chk("post_reset_cmd", log_c[0], 0);
      end

      // Randomized holds and backpressure against the model
      rb = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 4; k++)
            if ($urandom_range(7, 0) == 0) rb[k] = ~rb[k];
         step(rb, $urandom_range(3, 0) != 0);
      end
      idle(10);
      vcount = 0;
      for (int i = 0; i < 5; i++) begin
         step(4'b0000, 1'b1);
         if (cmd_valid) vcount++;
      end
      chk("drain_idle", vcount, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_cmd_sched.md
KEY_CMD_SCHED -- requirements
Module: key_cmd_sched

Interface
REQ-001 SHALL have parameter DELAY, default 20'd500000, meaning clk cycles from first fire to first auto-repeat (legal range >= 2).
REQ-002 SHALL have parameter RATE, default 20'd100000, meaning clk cycles between auto-repeats (legal range >= 2).
REQ-003 SHALL have parameter CNTW, default 20, meaning the width of the per-key counter, which must be wide enough to hold max(DELAY, RATE).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn, input, 4 bits: debounced key levels, where bit0 is left, bit1 is right, bit2 is rotate and bit3 is drop.
REQ-007 SHALL have port cmd_ready, input, 1 bit: the game logic accepts the command this cycle.
REQ-008 SHALL have port cmd_valid, output, 1 bit, registered: a command is presented.
REQ-009 SHALL have port cmd, output, 2 bits, registered: 00 left, 01 right, 10 rotate, 11 drop.

Function
REQ-010 SHALL run one key-repeat FSM per btn bit, with states IDLE, DELAY and REPEAT.
REQ-011 In IDLE with btn[i]=1, the FSM SHALL set pend[i], clear the counter and enter DELAY on the same edge.
REQ-012 In DELAY, the counter SHALL increment each cycle; at count==DELAY-1, left/right SHALL set pend, clear the counter and enter REPEAT.
REQ-013 Rotate and drop SHALL never auto-repeat; they stay in DELAY with the counter frozen at DELAY-1 until release.
REQ-014 In REPEAT, at count==RATE-1 the FSM SHALL set pend and clear the counter; otherwise it increments.
REQ-015 btn[i]=0 in any state SHALL return the FSM to IDLE and clear its counter on the next edge; pend[i] SHALL be kept.
REQ-016 A fire while pend[i] is already set SHALL coalesce: pend stays 1, no count accumulates.
REQ-017 When cmd_valid=0 or (cmd_valid=1 and cmd_ready=1), the arbiter SHALL load the highest-priority pend[i] (drop > rotate > left > right) into cmd, set cmd_valid, and clear that pend[i] on the same edge.
REQ-018 If no pend bit is set at a load opportunity, cmd_valid SHALL go to 0 on that edge.
REQ-019 While cmd_valid=1 and cmd_ready=0, cmd and cmd_valid SHALL hold unchanged.
REQ-020 Latency: btn[i] first sampled 1 at edge k, with no competing pend and a free output, SHALL give pend[i] after edge k and cmd_valid/cmd after edge k+1.
REQ-021 A fire and a grant of the same key on the same edge SHALL leave pend[i]=1, so the fire is not lost.
REQ-022 Left and right pending together SHALL both be delivered, left first.
REQ-023 The block SHALL sustain one command per cycle while cmd_ready is held at 1 and requests are pending.

Reset
REQ-024 rst=0 SHALL asynchronously force all FSMs to IDLE, all counters to 0, pend to 4'b0000, cmd_valid to 0 and cmd to 2'b00.
REQ-025 The first command after reset release SHALL require a fresh btn sample of 1; a key held through reset fires once on the first edge after release.

Structure
REQ-026 The command codes and FSM state encodings SHALL live in shared package key_cmd_pkg.
REQ-027 The per-key FSM, counter and pend bit SHALL be sub-module key_repeat, with a parameter selecting repeat or no-repeat; it SHALL be instantiated four times.
REQ-028 The arbiter and output register SHALL sit in key_cmd_sched itself.

Verification (DELAY=8, RATE=4, cmd_ready=1 unless stated)
REQ-029 Single tap: btn=0001 for 1 cycle -> exactly one cmd=00 pulse, 2 cycles after the edge; no further commands.
REQ-030 Hold left for 30 cycles -> cmd=00 at t=2, then at t=10, 14, 18, 22, 26, 30 (first repeat after 8 cycles, then every 4).
REQ-031 Hold drop for 30 cycles -> exactly one cmd=11.
REQ-032 btn=1111 pressed on the same edge -> cmd sequence 11, 10, 00, 01 on consecutive cycles.
REQ-033 Hold left with cmd_ready=0 for 20 cycles -> cmd_valid=1 and cmd=00 stable throughout; after cmd_ready rises, one extra cmd=00 (coalesced), not several.
REQ-034 rst pulsed low mid-REPEAT with cmd_valid=1 -> cmd_valid=0 immediately (asynchronous), pend cleared; btn still held -> new cmd=00 two cycles after release.
